// File: rtl/cache_txn_logger_pkg.sv
// ---------------------------------------------------------------------------
// cache_txn_logger_pkg : shared cache event encodings and the logger entry type
// Rev 1.0 | optional stamp field under CACHE_TXN_TIMESTAMP_EN
// ---------------------------------------------------------------------------
`default_nettype none

package cache_txn_logger_pkg;

  typedef enum logic [2:0] {
    BUS_NONE       = 3'd0,
    BUS_READ       = 3'd1,
    BUS_WRITE      = 3'd2,
    BUS_INVALIDATE = 3'd3,
    BUS_RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'd0,
    SNOOP_HIT   = 2'd1,
    SNOOP_HITM  = 2'd2
  } snoop_t;

  typedef enum logic [2:0] {
    MSG_NONE           = 3'd0,
    MSG_GETLINE        = 3'd1,
    MSG_SENDLINE       = 3'd2,
    MSG_INVALIDATELINE = 3'd3,
    MSG_EVICTLINE      = 3'd4
  } l2tol1_msg_t;

  localparam logic [2:0] CODE_MIN  = 3'd1;
  localparam logic [2:0] CODE_MAX  = 3'd4;
  localparam int         NUM_CODES = 4;

  typedef struct packed {
    logic        kind;
    logic [2:0]  code;
    logic [31:0] addr;
    logic [1:0]  snoop;
`ifdef CACHE_TXN_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } txn_entry_t;

  function automatic logic code_legal(input logic [2:0] code);
    return (code >= CODE_MIN) && (code <= CODE_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_txn_logger_if.sv
// ---------------------------------------------------------------------------
// cache_txn_logger_if : event inputs, print-port handshake and statistics
// Rev 1.0 | out_ts present only under CACHE_TXN_TIMESTAMP_EN
// ---------------------------------------------------------------------------
`default_nettype none

interface cache_txn_logger_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic                         bus_vld;
  logic [2:0]                   bus_op;
  logic [31:0]                  bus_addr;
  logic [1:0]                   bus_snoop;
  logic                         msg_vld;
  logic [2:0]                   msg_code;
  logic [31:0]                  msg_addr;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_kind;
  logic [2:0]                   out_code;
  logic [31:0]                  out_addr;
  logic [1:0]                   out_snoop;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic [4*CNT_W-1:0]           bus_cnt;
  logic [4*CNT_W-1:0]           msg_cnt;
  logic [CNT_W-1:0]             drop_cnt;
`ifdef CACHE_TXN_TIMESTAMP_EN
  logic [31:0]                  out_ts;
`endif

  modport master (
    output bus_vld, bus_op, bus_addr, bus_snoop,
    output msg_vld, msg_code, msg_addr, out_ready,
    input  out_valid, out_kind, out_code, out_addr, out_snoop,
`ifdef CACHE_TXN_TIMESTAMP_EN
    input  out_ts,
`endif
    input  fifo_count, bus_cnt, msg_cnt, drop_cnt
  );

  modport slave (
    input  bus_vld, bus_op, bus_addr, bus_snoop,
    input  msg_vld, msg_code, msg_addr, out_ready,
    output out_valid, out_kind, out_code, out_addr, out_snoop,
`ifdef CACHE_TXN_TIMESTAMP_EN
    output out_ts,
`endif
    output fifo_count, bus_cnt, msg_cnt, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/cache_txn_fifo.sv
// ---------------------------------------------------------------------------
// cache_txn_fifo : dual-push, single-pop FIFO of txn_entry_t with registered head
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_txn_fifo
  import cache_txn_logger_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rstb_comb,
  input  wire logic                       push_a_i,
  input  txn_entry_t                      data_a_i,
  input  wire logic                       push_b_i,
  input  txn_entry_t                      data_b_i,
  input  wire logic                       pop_i,
  output logic                            valid_o,
  output txn_entry_t                      head_o,
  output logic [$clog2(DEPTH+1)-1:0]      count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  txn_entry_t      mem_q [DEPTH];
  txn_entry_t      mem_d [DEPTH];
  txn_entry_t      head_q, head_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [0:0]      state_q, state_d;
  logic            w_pop;

  // push_b is only ever used together with push_a, so slot b follows slot a.
  always_comb begin
    w_pop = pop_i & (state_q == ST_ACTIVE);
    mem_d = mem_q;
    if (push_a_i) mem_d[wr_q] = data_a_i;
    if (push_b_i) mem_d[wr_q + PW'(1)] = data_b_i;
    wr_d    = wr_q + PW'(push_a_i) + PW'(push_b_i);
    rd_d    = rd_q + PW'(w_pop);
    count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(w_pop);
    // Head is pre-computed so the print port is driven straight from flops.
    head_d  = mem_d[rd_d];
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (push_a_i) state_d = ST_ACTIVE;
      ST_ACTIVE: if (count_d == '0) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstb_comb) begin
    if (!rstb_comb) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      state_q <= ST_EMPTY;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign valid_o = (state_q == ST_ACTIVE);
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cache_txn_logger.sv
// ---------------------------------------------------------------------------
// cache_txn_logger : merges L2 bus ops and L2-to-L1 messages into one log FIFO
// Rev 1.0 | CACHE_TXN_TIMESTAMP_EN adds a per-entry cycle stamp and out_ts
// ---------------------------------------------------------------------------
`default_nettype none

module cache_txn_logger
  import cache_txn_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rstb_comb,
  cache_txn_logger_if.slave  log_if
);

  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

  logic                w_valid, w_pop;
  logic [CW-1:0]       w_count;
  logic [CW:0]         w_free;
  logic                w_bus_legal, w_msg_legal, w_bus_wr, w_msg_wr;
  logic                w_push_a, w_push_b;
  logic [1:0]          w_drops;
  logic [CNT_W:0]      w_drop_sum;
  txn_entry_t          w_bus_e, w_msg_e, w_data_a, w_head;
  logic [CNT_W-1:0]    bus_cnt_q [NUM_CODES];
  logic [CNT_W-1:0]    msg_cnt_q [NUM_CODES];
  logic [CNT_W-1:0]    drop_q;
  logic [4*CNT_W-1:0]  w_bus_flat, w_msg_flat;
`ifdef CACHE_TXN_TIMESTAMP_EN
  logic [31:0]         ts_q;
`endif

  // A same-cycle pop frees its slot, and the bus event always claims space first.
  always_comb begin
    w_pop       = w_valid & log_if.out_ready;
    w_free      = DEPTH_W - {1'b0, w_count} + {{CW{1'b0}}, w_pop};
    w_bus_legal = code_legal(log_if.bus_op) && (log_if.bus_snoop <= SNOOP_HITM);
    w_msg_legal = code_legal(log_if.msg_code);
    w_bus_wr    = log_if.bus_vld & w_bus_legal & (w_free != '0);
    w_msg_wr    = log_if.msg_vld & w_msg_legal &
                  (w_free > (w_bus_wr ? (CW+1)'(1) : (CW+1)'(0)));
    w_drops     = 2'(log_if.bus_vld & ~w_bus_wr) + 2'(log_if.msg_vld & ~w_msg_wr);
    w_drop_sum  = {1'b0, drop_q} + (CNT_W+1)'(w_drops);

    w_bus_e       = '0;
    w_bus_e.kind  = 1'b0;
    w_bus_e.code  = log_if.bus_op;
    w_bus_e.addr  = log_if.bus_addr;
    w_bus_e.snoop = log_if.bus_snoop;
    w_msg_e       = '0;
    w_msg_e.kind  = 1'b1;
    w_msg_e.code  = log_if.msg_code;
    w_msg_e.addr  = log_if.msg_addr;
`ifdef CACHE_TXN_TIMESTAMP_EN
    w_bus_e.ts    = ts_q;
    w_msg_e.ts    = ts_q;
`endif
    w_push_a = w_bus_wr | w_msg_wr;
    w_push_b = w_bus_wr & w_msg_wr;
    w_data_a = w_bus_wr ? w_bus_e : w_msg_e;
  end

  cache_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstb_comb (rstb_comb),
    .push_a_i  (w_push_a),
    .data_a_i  (w_data_a),
    .push_b_i  (w_push_b),
    .data_b_i  (w_msg_e),
    .pop_i     (w_pop),
    .valid_o   (w_valid),
    .head_o    (w_head),
    .count_o   (w_count)
  );

  always_ff @(posedge clk or negedge rstb_comb) begin
    if (!rstb_comb) begin
      for (int k = 0; k < NUM_CODES; k++) begin
        bus_cnt_q[k] <= '0;
        msg_cnt_q[k] <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CODES; k++) begin
        if (w_bus_wr && (log_if.bus_op == 3'(k+1)) && (bus_cnt_q[k] != '1))
          bus_cnt_q[k] <= bus_cnt_q[k] + 1'b1;
        if (w_msg_wr && (log_if.msg_code == 3'(k+1)) && (msg_cnt_q[k] != '1))
          msg_cnt_q[k] <= msg_cnt_q[k] + 1'b1;
      end
      drop_q <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

`ifdef CACHE_TXN_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rstb_comb) begin
    if (!rstb_comb) ts_q <= '0;
    else            ts_q <= ts_q + 32'd1;
  end
  assign log_if.out_ts = w_head.ts;
`endif

  always_comb begin
    w_bus_flat = '0;
    w_msg_flat = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      w_bus_flat[k*CNT_W +: CNT_W] = bus_cnt_q[k];
      w_msg_flat[k*CNT_W +: CNT_W] = msg_cnt_q[k];
    end
  end

  assign log_if.out_valid  = w_valid;
  assign log_if.out_kind   = w_head.kind;
  assign log_if.out_code   = w_head.code;
  assign log_if.out_addr   = w_head.addr;
  assign log_if.out_snoop  = w_head.snoop;
  assign log_if.fifo_count = w_count;
  assign log_if.bus_cnt    = w_bus_flat;
  assign log_if.msg_cnt    = w_msg_flat;
  assign log_if.drop_cnt   = drop_q;

endmodule

`default_nettype wire

// File: doc/cache_txn_logger.md
Name: cache_txn_logger

Overview:
- Sits directly downstream of the L2 cache controller and consumes its two per-operation outputs: the bus operation (with snoop result) and the L2-to-L1 message.
- Merges both event streams into one ordered FIFO and drains it to the print/monitor interface over a valid/ready handshake.
- Keeps saturating per-type event counters and a dropped-event counter.
- Shares the cache's reset, so an n=8 clear flushes the log and the statistics together with the cache.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- CNT_W, 16, width of every statistics counter.

Ports:
- clk  in  1  clock
- rstb_comb  in  1  asynchronous, active-low reset (main reset ANDed with cache-clear)
- bus_vld  in  1  one-cycle strobe: bus operation issued this cycle
- bus_op  in  3  bus op code: 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM; 0 and 5-7 illegal
- bus_addr  in  32  bus operation address
- bus_snoop  in  2  snoop result: 0 NOHIT, 1 HIT, 2 HITM; 3 illegal
- msg_vld  in  1  one-cycle strobe: L2-to-L1 message issued this cycle
- msg_code  in  3  message code: 1 GETLINE, 2 SENDLINE, 3 INVALIDATELINE, 4 EVICTLINE; others illegal
- msg_addr  in  32  message address
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts the head entry
- out_kind  out  1  0 = bus entry, 1 = message entry
- out_code  out  3  op or message code of the head entry
- out_addr  out  32  address of the head entry
- out_snoop  out  2  snoop result; 0 for message entries
- fifo_count  out  $clog2(DEPTH+1)  current occupancy
- bus_cnt  out  4*CNT_W  per-op counters; slice k-1 counts code k
- msg_cnt  out  4*CNT_W  per-message counters; slice k-1 counts code k
- drop_cnt  out  CNT_W  events lost to overflow or illegal codes

Behaviour:
- Reset (asynchronous, active-low): FIFO empty; out_valid=0; out_kind/out_code/out_addr/out_snoop=0; fifo_count=0; all counters=0.
- Registered outputs only. An event strobed in cycle t is visible at the head no earlier than t+1.
- Pop occurs when out_valid & out_ready. Head fields must stay stable while out_valid=1 and out_ready=0.
- Push rules:
  - Up to two pushes per cycle.
  - When both strobes are high in the same cycle, the bus entry takes the older slot and the message entry the next.
  - Free space = DEPTH - count + pop; a pop in the same cycle frees its slot.
  - Both valid with exactly one slot free: bus entry written, message dropped.
  - No slot free: every strobed event is dropped.
- Illegal code (op or msg not in 1-4, or snoop 3): the event is not written, drop_cnt increments, and no per-type counter changes.
- Counters:
  - The per-type counter increments only when the event is written.
  - drop_cnt increments by 1 or 2 per cycle.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Pointers: read and write pointers wrap modulo DEPTH. count updates by +pushes-pop in a single cycle.
- Full with a simultaneous pop and one push: the push is accepted and count stays at DEPTH.
- Empty with a push and out_ready=1: no pop that cycle; the entry appears next cycle. There is no bypass.
- Reset asserted mid-drain (cache clear): contents are discarded immediately and out_valid drops asynchronously.
- Control FSM has two states:
  - EMPTY: count=0, out_valid=0.
  - ACTIVE: count>0.
  - EMPTY->ACTIVE on any push. ACTIVE->EMPTY when count reaches 0 after a pop with no push.

Optional Feature:
- Macro: CACHE_TXN_TIMESTAMP_EN.
- Defined: a free-running 32-bit cycle counter (reset 0, wraps) is stored with each entry, and an extra output port out_ts [31:0] presents the head entry's stamp. Both entries of a dual push carry the same stamp.
- Undefined: no counter, no out_ts port, and the FIFO width excludes the stamp.

Decomposition:
- Shared cache package holds:
  - bus_op_t, snoop_t and l2tol1_msg_t enums with the encodings above.
  - txn_entry_t struct: kind, code, addr, snoop, optional ts.
  - Localparams for the legal code range.
- One sub-module: cache_txn_fifo, a dual-push single-pop FIFO of txn_entry_t with count output. The arbitration, legality check and counters stay in the top.

Test Plan:
- Single bus READ 0x0000_1040 snoop HIT, out_ready=1 -> out_valid next cycle with kind=0 code=1 addr=0x0000_1040 snoop=1; bus_cnt[0]=1; count returns to 0 after the pop.
- Same-cycle bus WRITE 0xA0 and msg SENDLINE 0xA0 with out_ready=0 -> count=2; pops return the bus entry first, then the message; bus_cnt[1]=1, msg_cnt[1]=1.
- Fill 8 entries with out_ready=0, then a dual strobe -> both dropped, drop_cnt=2. Next cycle: a pop plus one push -> accepted, count stays 8.
- Count=7 and a dual strobe with no pop -> bus entry written, message dropped; count=8, drop_cnt=1.
- bus_op=6 strobed -> nothing written, drop_cnt=1, all bus_cnt unchanged.
- Four entries queued, rstb_comb pulsed low for one cycle -> out_valid=0, count=0 and all counters 0 during reset; normal logging resumes after release.
